// File: rtl/hdlc_pkg.sv
// Shared constants and types for the HDLC receive path.
package hdlc_pkg;

  localparam logic [7:0]  FLAG_PATTERN  = 8'h7E;
  // Window holds the oldest bit in bit 0: a 0 followed by seven 1s reads as 8'hFE.
  localparam logic [7:0]  ABORT_PATTERN = 8'hFE;
  localparam int unsigned STUFF_RUN     = 5;
  localparam int unsigned PATTERN_LEN   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } rx_state_t;

endpackage

// File: rtl/hdlc_rx_bitdet.sv
// Rx bit front end: input register, 8-bit pattern window, ones run counter,
// flag/abort detection and stuffed-zero tagging of each incoming bit.
module hdlc_rx_bitdet
  import hdlc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic data_bit,
  output logic data_stuff,
  output logic flag_det,
  output logic abort_det
);

  logic       rx_q,    rx_d;
  logic [7:0] win_q,   win_d;
  logic [2:0] ones_q,  ones_d;
  logic       bit_q,   bit_d;
  logic       stuff_q, stuff_d;
  logic       flag_q,  flag_d;
  logic       abort_q, abort_d;
  logic       flag_hit, abort_hit;

  always_comb begin
    rx_d      = rx;
    abort_hit = (win_q == ABORT_PATTERN);
    flag_hit  = (win_q == FLAG_PATTERN) && !abort_hit;
    bit_d     = rx_q;
    stuff_d   = !rx_q && (ones_q == 3'(STUFF_RUN));
    if (rx_q) begin
      ones_d = (ones_q == 3'd7) ? ones_q : ones_q + 3'd1;
    end else begin
      ones_d = '0;
    end
    // Restart the window after a flag so its trailing bits cannot seed another match.
    if (flag_hit) begin
      win_d = {rx_q, 7'b0};
    end else begin
      win_d = {rx_q, win_q[7:1]};
    end
    flag_d  = flag_hit;
    abort_d = abort_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q    <= 1'b0;
      win_q   <= '0;
      ones_q  <= '0;
      bit_q   <= 1'b0;
      stuff_q <= 1'b0;
      flag_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      rx_q    <= rx_d;
      win_q   <= win_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      stuff_q <= stuff_d;
      flag_q  <= flag_d;
      abort_q <= abort_d;
    end
  end

  assign data_bit   = bit_q;
  assign data_stuff = stuff_q;
  assign flag_det   = flag_q;
  assign abort_det  = abort_q;

endmodule

// File: rtl/hdlc_rx_framer.sv
// HDLC receive framer: delays de-stuffed bits past flag/abort detection,
// assembles LSB-first bytes and sequences frame status strobes.
module hdlc_rx_framer
  import hdlc_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 128,
  parameter int unsigned LAT       = 10
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_AbortSignal,
  output logic       Rx_ValidFrame,
  output logic       Rx_NewByte,
  output logic [7:0] Rx_Data,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic       Rx_Overflow,
  output logic [7:0] Rx_ByteCnt
);

  // Two cycles are spent in the bit front end; LAT must be at least 10 so the
  // line still holds every bit of a pattern when its detection arrives.
  localparam int unsigned   DL       = LAT - 2;
  localparam logic [DL-1:0] PAT_MASK = DL'(8'hFF);
  localparam logic [7:0]    MAX_CNT  = 8'(MAX_BYTES);

  logic bit_in, stuff_in, flag_det, abort_det;

  hdlc_rx_bitdet u_bitdet (
    .clk        (Clk),
    .rst        (Rst),
    .rx         (Rx),
    .data_bit   (bit_in),
    .data_stuff (stuff_in),
    .flag_det   (flag_det),
    .abort_det  (abort_det)
  );

  rx_state_t   state_q,     state_d;
  logic [DL-1:0] dl_bit_q,  dl_bit_d;
  logic [DL-1:0] dl_vld_q,  dl_vld_d;
  logic [DL-1:0] dl_vld_m;
  logic [2:0]  bit_cnt_q,   bit_cnt_d;
  logic [7:0]  byte_cnt_q,  byte_cnt_d;
  logic [7:0]  shreg_q,     shreg_d;
  logic [7:0]  data_q,      data_d;
  logic        newbyte_q,   newbyte_d;
  logic        ovf_q,       ovf_d;
  logic        asig_q,      asig_d;
  logic        eof_pend_q,  eof_pend_d;
  logic        ferr_pend_q, ferr_pend_d;
  logic        eof_q,       eof_d;
  logic        ferr_q,      ferr_d;
  logic        out_bit, out_vld, accept;

  // On detection the newest PATTERN_LEN entries are exactly the pattern bits.
  always_comb begin
    dl_vld_m = (flag_det || abort_det) ? (dl_vld_q & ~PAT_MASK) : dl_vld_q;
    dl_bit_d = {dl_bit_q[DL-2:0], bit_in};
    dl_vld_d = {dl_vld_m[DL-2:0], ~stuff_in};
    out_bit  = dl_bit_q[DL-1];
    out_vld  = dl_vld_m[DL-1];
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    newbyte_d   = 1'b0;
    ovf_d       = ovf_q;
    asig_d      = 1'b0;
    eof_pend_d  = 1'b0;
    ferr_pend_d = 1'b0;
    eof_d       = eof_pend_q;
    ferr_d      = eof_pend_q && ferr_pend_q;
    accept      = (state_q == FRAME) && out_vld;

    if (accept) begin
      shreg_d   = {out_bit, shreg_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        if (byte_cnt_q < MAX_CNT) begin
          data_d     = {out_bit, shreg_q[7:1]};
          newbyte_d  = 1'b1;
          byte_cnt_d = byte_cnt_q + 8'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (flag_det) begin
          state_d    = FRAME;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          shreg_d    = '0;
          ovf_d      = 1'b0;
        end
      end
      FRAME: begin
        if (abort_det) begin
          state_d    = IDLE;
          asig_d     = 1'b1;
          eof_pend_d = 1'b1;
        end else if (flag_det && !(byte_cnt_q == '0 && bit_cnt_q == '0)) begin
          state_d     = IDLE;
          eof_pend_d  = 1'b1;
          ferr_pend_d = (bit_cnt_q != '0);
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      dl_bit_q    <= '0;
      dl_vld_q    <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      newbyte_q   <= 1'b0;
      ovf_q       <= 1'b0;
      asig_q      <= 1'b0;
      eof_pend_q  <= 1'b0;
      ferr_pend_q <= 1'b0;
      eof_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_bit_q    <= dl_bit_d;
      dl_vld_q    <= dl_vld_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      newbyte_q   <= newbyte_d;
      ovf_q       <= ovf_d;
      asig_q      <= asig_d;
      eof_pend_q  <= eof_pend_d;
      ferr_pend_q <= ferr_pend_d;
      eof_q       <= eof_d;
      ferr_q      <= ferr_d;
    end
  end

  assign Rx_FlagDetect  = flag_det;
  assign Rx_AbortDetect = abort_det;
  assign Rx_AbortSignal = asig_q;
  assign Rx_ValidFrame  = (state_q == FRAME);
  assign Rx_NewByte     = newbyte_q;
  assign Rx_Data        = data_q;
  assign Rx_EoF         = eof_q;
  assign Rx_FrameError  = ferr_q;
  assign Rx_Overflow    = ovf_q;
  assign Rx_ByteCnt     = byte_cnt_q;

endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Scoreboard bench for hdlc_rx_framer: stimulus queues expected strobes with
// their cycle numbers; a negedge monitor pops and compares them.
module tb_hdlc_rx_framer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Rx  = 1'b0;
  logic       Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame;
  logic       Rx_NewByte, Rx_EoF, Rx_FrameError, Rx_Overflow;
  logic [7:0] Rx_Data, Rx_ByteCnt;

  hdlc_rx_framer #(.MAX_BYTES(128), .LAT(10)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Rx             (Rx),
    .Rx_FlagDetect  (Rx_FlagDetect),
    .Rx_AbortDetect (Rx_AbortDetect),
    .Rx_AbortSignal (Rx_AbortSignal),
    .Rx_ValidFrame  (Rx_ValidFrame),
    .Rx_NewByte     (Rx_NewByte),
    .Rx_Data        (Rx_Data),
    .Rx_EoF         (Rx_EoF),
    .Rx_FrameError  (Rx_FrameError),
    .Rx_Overflow    (Rx_Overflow),
    .Rx_ByteCnt     (Rx_ByteCnt)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] data; } byte_exp_t;
  typedef struct { int cyc; logic ferr; logic [7:0] cnt; logic ovf; } eof_exp_t;
  typedef struct { int cyc; int which; logic [23:0] val; } lvl_exp_t;

  localparam int L_OVF = 0, L_CNT = 1, L_VALID = 2, L_ALL = 3;

  int        q_flag[$];
  int        q_abort[$];
  int        q_asig[$];
  byte_exp_t q_byte[$];
  eof_exp_t  q_eof[$];
  lvl_exp_t  q_lvl[$];

  int errors = 0;
  int checks = 0;
  int last_k;
  int tx_ones = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] lvl_actual(input int which);
    case (which)
      L_OVF:   return {23'd0, Rx_Overflow};
      L_CNT:   return {16'd0, Rx_ByteCnt};
      L_VALID: return {23'd0, Rx_ValidFrame};
      default: return {Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame,
                       Rx_NewByte, Rx_Data, Rx_EoF, Rx_FrameError, Rx_Overflow, Rx_ByteCnt};
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic vf1 = 1'b0, vf2 = 1'b0;
  always @(negedge Clk) begin : monitor
    lvl_exp_t  le;
    byte_exp_t be;
    eof_exp_t  ee;
    while (q_lvl.size() > 0 && q_lvl[0].cyc <= cyc) begin
      le = q_lvl.pop_front();
      check($sformatf("level%0d_c%0d", le.which, le.cyc),
            (le.cyc == cyc) ? int'(lvl_actual(le.which)) : -2, int'(le.val));
    end

    if (Rx_FlagDetect === 1'b1)
      check("flag_detect_cycle", cyc, (q_flag.size() > 0) ? q_flag.pop_front() : -1);
    while (q_flag.size() > 0 && q_flag[0] < cyc) check("flag_detect_missing", -1, q_flag.pop_front());

    if (Rx_AbortDetect === 1'b1)
      check("abort_detect_cycle", cyc, (q_abort.size() > 0) ? q_abort.pop_front() : -1);
    while (q_abort.size() > 0 && q_abort[0] < cyc) check("abort_detect_missing", -1, q_abort.pop_front());

    if (Rx_AbortSignal === 1'b1)
      check("abort_signal_cycle", cyc, (q_asig.size() > 0) ? q_asig.pop_front() : -1);
    while (q_asig.size() > 0 && q_asig[0] < cyc) check("abort_signal_missing", -1, q_asig.pop_front());

    if (Rx_NewByte === 1'b1) begin
      if (q_byte.size() == 0) begin
        check("newbyte_unexpected", cyc, -1);
      end else begin
        be = q_byte.pop_front();
        check("newbyte_cycle", cyc, be.cyc);
        check("newbyte_data", int'(Rx_Data), int'(be.data));
        check("newbyte_in_frame", int'(Rx_ValidFrame), 1);
        check("newbyte_no_overflow", int'(Rx_Overflow), 0);
      end
    end
    while (q_byte.size() > 0 && q_byte[0].cyc < cyc) begin
      be = q_byte.pop_front();
      check("newbyte_missing", -1, be.cyc);
    end

    if (Rx_EoF === 1'b1) begin
      if (q_eof.size() == 0) begin
        check("eof_unexpected", cyc, -1);
      end else begin
        ee = q_eof.pop_front();
        check("eof_cycle", cyc, ee.cyc);
        check("eof_frame_error", int'(Rx_FrameError), int'(ee.ferr));
        check("eof_byte_cnt", int'(Rx_ByteCnt), int'(ee.cnt));
        check("eof_overflow", int'(Rx_Overflow), int'(ee.ovf));
        check("eof_valid_fell_prev", int'({vf2, vf1}), 2);
      end
    end
    while (q_eof.size() > 0 && q_eof[0].cyc < cyc) begin
      ee = q_eof.pop_front();
      check("eof_missing", -1, ee.cyc);
    end

    if (Rx_FrameError === 1'b1 && Rx_EoF !== 1'b1)
      check("frame_error_without_eof", 1, 0);

    vf2 = vf1;
    vf1 = Rx_ValidFrame;
  end

  // ---------------- stimulus ----------------
  task automatic send_raw(input logic b);
    @(negedge Clk);
    Rx = b;
    last_k = cyc + 1;
  endtask

  task automatic send_pattern(input logic [7:0] p);
    for (int i = 0; i < 8; i++) send_raw(p[i]);
    tx_ones = 0;
  endtask

  task automatic send_data_bit(input logic b, output int k);
    send_raw(b);
    k = last_k;
    tx_ones = b ? tx_ones + 1 : 0;
    if (tx_ones == 5) begin
      send_raw(1'b0);
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit exp_nb, output int k8);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) send_data_bit(v[i], k);
    k8 = k;
    if (exp_nb) q_byte.push_back('{k8 + 10, v});
  endtask

  task automatic send_flag();
    send_pattern(8'h7E);
    q_flag.push_back(last_k + 2);
  endtask

  task automatic close_frame(input logic ferr, input logic [7:0] cnt, input logic ovf);
    send_flag();
    q_eof.push_back('{last_k + 4, ferr, cnt, ovf});
  endtask

  task automatic idle_zeros(input int n);
    for (int i = 0; i < n; i++) send_raw(1'b0);
  endtask

  initial begin : stim
    int k;
    logic [3:0] tail4;
    logic [2:0] tail3;
    k = 0;
    q_lvl.push_back('{2, L_ALL, 24'd0});
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    idle_zeros(4);

    // Two-byte frame A5, 3C
    send_flag();
    send_byte(8'hA5, 1'b1, k);
    send_byte(8'h3C, 1'b1, k);
    close_frame(1'b0, 8'd2, 1'b0);
    idle_zeros(6);

    // 8'hFF needs a stuffed zero after five ones
    send_flag();
    send_byte(8'hFF, 1'b1, k);
    close_frame(1'b0, 8'd1, 1'b0);
    idle_zeros(6);

    // 12 data bits then an abort inside the frame
    send_flag();
    send_byte(8'h5A, 1'b1, k);
    tail4 = 4'b1011;
    for (int i = 0; i < 4; i++) send_data_bit(tail4[i], k);
    send_pattern(8'hFE);
    q_abort.push_back(last_k + 2);
    q_asig.push_back(last_k + 3);
    q_eof.push_back('{last_k + 4, 1'b0, 8'd1, 1'b0});

    // Idle ones, then an abort with no frame open
    for (int i = 0; i < 10; i++) send_raw(1'b1);
    send_pattern(8'hFE);
    q_abort.push_back(last_k + 2);

    // 130 bytes: 128 accepted, overflow on byte 129
    send_flag();
    for (int b = 0; b < 130; b++) begin
      send_byte(8'h55, (b < 128), k);
      if (b == 128) begin
        q_lvl.push_back('{k + 9,  L_OVF, 24'd0});
        q_lvl.push_back('{k + 10, L_OVF, 24'd1});
      end
    end
    close_frame(1'b0, 8'd128, 1'b1);
    idle_zeros(4);

    // Next opening flag clears the sticky overflow
    send_flag();
    q_lvl.push_back('{last_k + 2, L_OVF, 24'd1});
    q_lvl.push_back('{last_k + 3, L_OVF, 24'd0});
    q_lvl.push_back('{last_k + 3, L_CNT, 24'd0});
    send_byte(8'h81, 1'b1, k);
    close_frame(1'b0, 8'd1, 1'b0);
    idle_zeros(6);

    // 11 data bits: frame error
    send_flag();
    send_byte(8'h96, 1'b1, k);
    tail3 = 3'b011;
    for (int i = 0; i < 3; i++) send_data_bit(tail3[i], k);
    close_frame(1'b1, 8'd1, 1'b0);
    idle_zeros(6);

    // Reset mid-frame before the first byte emerges: everything clears, no EoF
    send_flag();
    send_byte(8'h0F, 1'b0, k);
    tail3 = 3'b101;
    for (int i = 0; i < 3; i++) send_data_bit(tail3[i], k);
    q_lvl.push_back('{last_k, L_VALID, 24'd1});
    @(negedge Clk);
    Rst = 1'b1;
    Rx  = 1'b0;
    q_lvl.push_back('{cyc + 1, L_ALL, 24'd0});
    @(negedge Clk);
    Rst = 1'b0;
    idle_zeros(30);

    check("flag_queue_drained",  q_flag.size(),  0);
    check("abort_queue_drained", q_abort.size(), 0);
    check("asig_queue_drained",  q_asig.size(),  0);
    check("byte_queue_drained",  q_byte.size(),  0);
    check("eof_queue_drained",   q_eof.size(),   0);
    check("level_queue_drained", q_lvl.size(),   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
